// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: iterative shift-add multiplier that owns the HI/LO registers.
// Decodes MULT/MFHI/MFLO/MTHI/MTLO from the ALU control code. While a multiply
// is running, it stalls the issuing stage for any of those codes.
// Optional build macro MULT_EARLY_TERM_EN: ends the multiply once the remaining
// multiplier bits are all zero. Without it the latency is always 33 edges.
module mult_hilo_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CTRL_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [CTRL_WIDTH-1:0] op_ctrl,
    input  logic                  op_signed,
    input  logic [DATA_WIDTH-1:0] src_a,
    input  logic [DATA_WIDTH-1:0] src_b,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  stall,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CTRL_WIDTH-1:0] OP_MULT = CTRL_WIDTH'(4'h6);
    localparam logic [CTRL_WIDTH-1:0] OP_MFHI = CTRL_WIDTH'(4'hB);
    localparam logic [CTRL_WIDTH-1:0] OP_MFLO = CTRL_WIDTH'(4'hC);
    localparam logic [CTRL_WIDTH-1:0] OP_MTHI = CTRL_WIDTH'(4'hD);
    localparam logic [CTRL_WIDTH-1:0] OP_MTLO = CTRL_WIDTH'(4'hE);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN} state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   mcand;
    logic [DATA_WIDTH-1:0]   mplier;
    logic [2*DATA_WIDTH-1:0] acc;
    logic [CW-1:0]           cnt;
    logic                    sign_q;

    logic                    is_op;
    logic [DATA_WIDTH-1:0]   a_abs;
    logic [DATA_WIDTH-1:0]   b_abs;
    logic [DATA_WIDTH:0]     add_sum;
    logic [2*DATA_WIDTH-1:0] acc_next;
    logic [DATA_WIDTH-1:0]   mplier_next;

    // Decode, operand magnitudes, and one shift-add step of the datapath.
    always_comb begin
        is_op = (op_ctrl == OP_MULT) || (op_ctrl == OP_MFHI) || (op_ctrl == OP_MFLO) ||
                (op_ctrl == OP_MTHI) || (op_ctrl == OP_MTLO);
        // -0x80000000 wraps back to 0x80000000. That value is the correct magnitude read as unsigned.
        a_abs = (op_signed && src_a[DATA_WIDTH-1]) ? -src_a : src_a;
        b_abs = (op_signed && src_b[DATA_WIDTH-1]) ? -src_b : src_b;
        add_sum = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} +
                  {1'b0, (mplier[0] ? mcand : {DATA_WIDTH{1'b0}})};
        // The carry out of the add becomes the new MSB when the accumulator shifts right.
        acc_next    = {add_sum, acc[DATA_WIDTH-1:1]};
        mplier_next = mplier >> 1;
        busy  = (state != S_IDLE);
        stall = op_valid && busy && is_op;
        rd_data = (op_ctrl == OP_MFHI) ? hi :
                  (op_ctrl == OP_MFLO) ? lo : {DATA_WIDTH{1'b0}};
    end

    // Control FSM: accepts ops in IDLE, iterates in MUL, writes the product in FIN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            sign_q <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op_ctrl)
                            OP_MULT: begin
                                mcand  <= a_abs;
                                mplier <= b_abs;
                                sign_q <= op_signed & (src_a[DATA_WIDTH-1] ^ src_b[DATA_WIDTH-1]);
                                acc    <= '0;
                                cnt    <= CW'(DATA_WIDTH - 1);
                                state  <= S_MUL;
                            end
                            OP_MTHI: hi <= src_a;
                            OP_MTLO: lo <= src_a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    mplier <= mplier_next;
                    cnt    <= cnt - 1'b1;
`ifdef MULT_EARLY_TERM_EN
                    // No set bits remain, so skip the empty iterations. Apply all remaining shifts in this one edge.
                    if (mplier_next == '0) begin
                        acc   <= acc_next >> cnt;
                        state <= S_FIN;
                    end else begin
                        acc <= acc_next;
                        if (cnt == '0) state <= S_FIN;
                    end
`else
                    acc <= acc_next;
                    if (cnt == '0) state <= S_FIN;
`endif
                end
                S_FIN: begin
                    {hi, lo} <= sign_q ? -acc : acc;
                    done     <= 1'b1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
